// File: rtl/seven_seg_reader.sv
// seven_seg_reader: decodes a multiplexed active-low seven-segment bus back into a hex word
module seven_seg_reader #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            Seg_in,
   input  logic [DIGITS-1:0]     Dig_sel,
   output logic [4*DIGITS-1:0]   Word_out,
   output logic                  Word_valid,
   output logic [DIGITS-1:0]     Digit_err
);
   typedef enum logic [1:0] {WAIT_SEL, DWELL, HELD} state_t;
   state_t state, state_next;
   logic [6:0]          seg_q, seg_p;
   logic [DIGITS-1:0]   sel_q, sel_p, sel_n, seen, seen_next, slot_err;
   logic [4*DIGITS-1:0] slot_nib;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                changed, legal, capture, full;
   logic [4:0]          dec;

   // returns {error, nibble}; blank is a legal "0" so dark digits do not flag errors
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b1000000: decode = 5'h00;
         7'b1111001: decode = 5'h01;
         7'b0100100: decode = 5'h02;
         7'b0110000: decode = 5'h03;
         7'b0011001: decode = 5'h04;
         7'b0010010: decode = 5'h05;
         7'b0000010: decode = 5'h06;
         7'b1111000: decode = 5'h07;
         7'b0000000: decode = 5'h08;
         7'b0011000: decode = 5'h09;
         7'b0001000: decode = 5'h0A;
         7'b0000011: decode = 5'h0B;
         7'b1000110: decode = 5'h0C;
         7'b0100001: decode = 5'h0D;
         7'b0000110: decode = 5'h0E;
         7'b0001110: decode = 5'h0F;
         7'b1111111: decode = 5'h00;
         default:    decode = 5'h10;
      endcase
   endfunction

   assign changed   = {seg_q, sel_q} != {seg_p, sel_p};
   assign sel_n     = ~sel_q;
   assign legal     = $countones(sel_n) == 1;
   assign cnt_next  = changed ? CNT_W'(1) : (cnt == CNT_W'(STABLE_CYCLES) ? cnt : cnt + CNT_W'(1));
   assign dec       = decode(seg_q);
   assign seen_next = (full ? '0 : seen) | (capture ? sel_n : '0);

   // capture fires once per stable legal dwell; HELD blocks repeats until the bus changes
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         WAIT_SEL: state_next = legal ? DWELL : WAIT_SEL;
         DWELL: begin
            if (!legal) state_next = WAIT_SEL;
            else if (cnt_next == CNT_W'(STABLE_CYCLES)) begin
               capture    = 1'b1;
               state_next = HELD;
            end
         end
         HELD:    state_next = changed ? (legal ? DWELL : WAIT_SEL) : HELD;
         default: state_next = WAIT_SEL;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= WAIT_SEL;
      else      state <= state_next;
   end

   // input sampling with one-deep history and saturating stability count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= 7'h7F;
         sel_q <= '1;
         seg_p <= 7'h7F;
         sel_p <= '1;
         cnt   <= '0;
      end else begin
         seg_q <= Seg_in;
         sel_q <= Dig_sel;
         seg_p <= seg_q;
         sel_p <= sel_q;
         cnt   <= cnt_next;
      end
   end

   // slot capture and frame publication one edge after the last missing digit lands
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_nib   <= '0;
         slot_err   <= '0;
         seen       <= '0;
         full       <= 1'b0;
         Word_valid <= 1'b0;
         Word_out   <= '0;
         Digit_err  <= '0;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (capture && sel_n[i]) begin
               slot_nib[4*i +: 4] <= dec[3:0];
               slot_err[i]        <= dec[4];
            end
         end
         seen       <= seen_next;
         full       <= capture && (&seen_next);
         Word_valid <= full;
         if (full) begin
            Word_out  <= slot_nib;
            Digit_err <= slot_err;
         end
      end
   end
endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Reads a time-multiplexed, active-low seven-segment display bus (shared segment lines plus per-digit select).
- Qualifies each stable digit pattern and decodes it back to a 4-bit hex value.
- Assembles DIGITS nibbles into one word and pulses a valid strobe when every digit has been captured.
- Used as a display-side monitor/readback path for the hex display drivers, and in self-check benches.

Parameters:
- DIGITS, 4, number of multiplexed digits; word width is 4*DIGITS.
- STABLE_CYCLES, 4, consecutive identical registered samples required before a capture (minimum 2).
- CNT_W, 3, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- Seg_in  input  7  segment lines, active-low, bit0=a … bit6=g.
- Dig_sel  input  DIGITS  digit enables, active-low, one-hot-low when legal; bit i = digit i.
- Word_out  output  4*DIGITS  last completed frame; digit i occupies bits [4i+3:4i].
- Word_valid  output  1  one-cycle pulse when Word_out is updated.
- Digit_err  output  DIGITS  per-digit invalid-pattern flags for the frame in Word_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - Word_out=0, Word_valid=0, Digit_err=0.
  - Input register = {7'h7F, all-ones}.
  - Stability counter=0; slot registers and seen mask cleared.
  - State = WAIT_SEL.
  - Asserting reset mid-frame discards all partial captures.
- Input stage: Seg_in and Dig_sel are registered once (pair S). The previous S is kept for comparison.
- Stability counter:
  - Loads 1 when S differs from the previous S.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Legal select: Dig_sel has exactly one bit low. Any other value (all high, or multiple low) is illegal.
- State machine:
  - WAIT_SEL: select illegal. Go to DWELL when S holds a legal select.
  - DWELL: counting. Capture on the edge where the counter reaches STABLE_CYCLES with S legal, then go to HELD. Any change in S restarts the count. An illegal select goes to WAIT_SEL.
  - HELD: captured, no re-capture. Leave on any change in S: to DWELL if the new select is legal, else to WAIT_SEL.
- Decode:
  - 0..F use the team hex display table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Blank (1111111) decodes to 0 with no error.
  - Any other pattern decodes to 0 and sets the slot error bit.
- Capture into slot i:
  - Writes nibble and error bit, and sets seen[i].
  - Re-capture of an already-seen digit before frame completion overwrites it (latest wins).
- Frame completion:
  - When a capture makes seen all-ones, the next edge loads Word_out and Digit_err from the slots.
  - Word_valid is high for exactly that one cycle; seen clears on the same edge.
  - A capture landing on that completion edge counts toward the next frame.
- Latency: pin change to capture = 1 (input register) + STABLE_CYCLES edges. Capture to Word_valid = 1 edge.
- Word_out and Digit_err hold between frames. Word_valid is never high on two consecutive cycles.

Test Plan:
- Reset mid-frame: capture digits 0–1, pulse rst low for 2 cycles, then drive all four digits → Word_valid only after all four post-reset captures; outputs read 0 during reset.
- Normal frame (DIGITS=4, STABLE_CYCLES=4): digits 0..3 = 0110000, 0001000, 1000000, 0001110, each held 8 cycles with Dig_sel 1110/1101/1011/0111 → Word_out=16'hF0A3, Digit_err=0, a single Word_valid pulse 1 edge after the digit-3 capture.
- Glitch rejection: digit 0 pattern held 3 cycles, then changed → no capture, seen unchanged, no Word_valid.
- Invalid pattern: digit 2 = 1111110, others valid (1,2,3) → Word_out=16'h3021... specifically nibble2=0, Digit_err=4'b0100.
- Illegal select: Dig_sel=1100 for 10 cycles with a valid pattern → no capture; then legal digits complete the frame normally.
- Overwrite: digit 1 captured as 5 (0010010), then as 7 (1111000) before the frame completes → nibble1=7; dwelling 20 cycles on one digit yields a single capture only.
